ldiv_floor_collect: RTL and testbench

- Downstream companion of the pipelined signed/unsigned long divider. Consumes its truncating quotient/remainder result stream.
- Converts each result to floor-division form (quotient rounded toward minus infinity, non-negative modulus).
- Buffers results in a FIFO with a ready/valid consumer port. The divider cannot stall, so the block also issues credit to the divider's producer.
- Credit = FIFO space minus results already in flight through the divider.

---
 rtl/ldiv_floor_collect.sv | 126 ++++++++++++
 tb/tb_ldiv_floor_collect.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldiv_floor_collect.sv
// ldiv_floor_collect: floor-division correction of divider results, show-ahead result FIFO
// and credit issue to the divider's producer (credit = FIFO space minus results in flight).
module ldiv_floor_collect #(
    parameter int NUMERATOR_WIDTH   = 10,
    parameter int DENOMINATOR_WIDTH = 10,
    parameter int QUOTIENT_WIDTH    = 10,
    parameter int DEPTH             = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_issue,
    output logic                         o_can_issue,
    input  logic                         i_valid,
    input  logic [QUOTIENT_WIDTH-1:0]    i_quotient,
    input  logic [NUMERATOR_WIDTH-1:0]   i_remainder,
    input  logic [DENOMINATOR_WIDTH-1:0] i_denominator,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [QUOTIENT_WIDTH-1:0]    o_quotient,
    output logic [DENOMINATOR_WIDTH-1:0] o_modulus,
    output logic                         o_div_by_zero,
    output logic                         o_overflow
);
    localparam int NW = NUMERATOR_WIDTH;
    localparam int DW = DENOMINATOR_WIDTH;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = (NW > DW ? NW : DW) + 1;

    logic [MW-1:0] w_rem_ext;
    logic [MW-1:0] w_mod_sum;
    logic          w_fix;
    logic [QW-1:0] w_q_next;
    logic [DW-1:0] w_mod_next;

    logic          r_s_valid;
    logic [QW-1:0] r_s_q;
    logic [DW-1:0] r_s_mod;
    logic          r_s_dz;

    logic [QW-1:0] r_mem_q [DEPTH];
    logic [DW-1:0] r_mem_m [DEPTH];
    logic          r_mem_z [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic          r_overflow;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [CW:0]   w_used;

    // Truncated remainder carries the numerator's sign; a negative one with a
    // nonzero divisor is folded into [1, d-1] and the quotient stepped down.
    assign w_rem_ext  = MW'($signed(i_remainder));
    assign w_mod_sum  = w_rem_ext + MW'(i_denominator);
    assign w_fix      = (i_denominator != '0) && i_remainder[NW-1];
    assign w_q_next   = w_fix ? i_quotient - QW'(1) : i_quotient;
    assign w_mod_next = w_fix ? w_mod_sum[DW-1:0] : w_rem_ext[DW-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_valid <= 1'b0;
            r_s_q     <= '0;
            r_s_mod   <= '0;
            r_s_dz    <= 1'b0;
        end else begin
            r_s_valid <= i_valid;
            if (i_valid) begin
                r_s_q   <= w_q_next;
                r_s_mod <= w_mod_next;
                r_s_dz  <= i_denominator == '0;
            end
        end
    end

    assign w_full  = r_count == CW'(DEPTH);
    assign w_empty = r_count == '0;
    assign w_pop   = !w_empty && i_ready;
    assign w_push  = r_s_valid && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_q[r_wr] <= r_s_q;
            r_mem_m[r_wr] <= r_s_mod;
            r_mem_z[r_wr] <= r_s_dz;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr       <= r_wr + AW'(w_push);
            r_rd       <= r_rd + AW'(w_pop);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_overflow <= r_overflow || (r_s_valid && !w_push);
        end
    end

    // A return with nothing in flight is ignored rather than wrapping below zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= (i_issue && !i_valid) ? r_inflight + CW'(1) :
                          (i_valid && !i_issue && r_inflight != '0) ? r_inflight - CW'(1) :
                          r_inflight;
        end
    end

    assign w_used        = (CW+1)'(r_inflight) + (CW+1)'(r_s_valid) + (CW+1)'(r_count);
    assign o_can_issue   = w_used < (CW+1)'(DEPTH);
    assign o_valid       = !w_empty;
    assign o_quotient    = w_empty ? '0 : r_mem_q[r_rd];
    assign o_modulus     = w_empty ? '0 : r_mem_m[r_rd];
    assign o_div_by_zero = w_empty ? 1'b0 : r_mem_z[r_rd];
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_ldiv_floor_collect.sv
// tb_ldiv_floor_collect: directed checks of floor correction, FIFO credit, overflow,
// streaming order and asynchronous reset for ldiv_floor_collect at DEPTH=4.
module tb_ldiv_floor_collect;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue = 1'b0;
    logic       valid = 1'b0;
    logic       ready = 1'b0;
    logic [9:0] q_in = '0;
    logic [9:0] r_in = '0;
    logic [9:0] d_in = '0;
    logic       can_issue;
    logic       o_valid;
    logic [9:0] o_q;
    logic [9:0] o_m;
    logic       o_z;
    logic       ovf;
    int         n_cmp = 0;
    int         n_bad = 0;

    ldiv_floor_collect #(
        .NUMERATOR_WIDTH(10), .DENOMINATOR_WIDTH(10), .QUOTIENT_WIDTH(10), .DEPTH(D)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_issue(issue), .o_can_issue(can_issue),
        .i_valid(valid), .i_quotient(q_in), .i_remainder(r_in), .i_denominator(d_in),
        .o_valid(o_valid), .i_ready(ready), .o_quotient(o_q), .o_modulus(o_m),
        .o_div_by_zero(o_z), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int q, input int r, input int d);
        valid = 1'b1;
        q_in = 10'(q);
        r_in = 10'(r);
        d_in = 10'(d);
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", ovf); end
        n_cmp++; if (can_issue !== 1'b1) begin n_bad++; $display("FAIL reset_can_issue: got %b want 1", can_issue); end
        n_cmp++; if ({o_q, o_m, o_z} !== 21'd0) begin n_bad++; $display("FAIL reset_data: got q=%0d m=%0d z=%b want zeros", o_q, o_m, o_z); end
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_floor;
        int tq[5] = '{-3, 3, -2, -1, -512};
        int tr[5] = '{-1, 1, 0, 5, -1};
        int td[5] = '{2, 2, 3, 0, 3};
        int eq[5] = '{-4, 3, -2, -1, 511};
        int em[5] = '{1, 1, 0, 5, 2};
        logic ez[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(tq[i], tr[i], td[i]);
            step;
            valid = 1'b0;
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL floor%0d_latency_early: got %b want 0", i, o_valid); end
            step;
            n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL floor%0d_latency: got %b want 1", i, o_valid); end
            n_cmp++; if (o_q !== 10'(eq[i])) begin n_bad++; $display("FAIL floor%0d_quotient: got %0d want %0d", i, $signed(o_q), eq[i]); end
            n_cmp++; if (o_m !== 10'(em[i])) begin n_bad++; $display("FAIL floor%0d_modulus: got %0d want %0d", i, o_m, em[i]); end
            n_cmp++; if (o_z !== ez[i]) begin n_bad++; $display("FAIL floor%0d_div_by_zero: got %b want %b", i, o_z, ez[i]); end
            ready = 1'b1;
            step;
            ready = 1'b0;
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL floor%0d_pop: got %b want 0", i, o_valid); end
        end
    endtask

    task automatic test_credit;
        n_cmp++; if (can_issue !== 1'b1) begin n_bad++; $display("FAIL credit_start: got %b want 1", can_issue); end
        for (int i = 0; i < 4; i++) begin
            issue = 1'b1;
            step;
            n_cmp++; if (can_issue !== (i < 3)) begin n_bad++; $display("FAIL credit_issue%0d: got %b want %b", i, can_issue, i < 3); end
        end
        issue = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(20 + i, 0, 1);
            step;
            n_cmp++; if (can_issue !== 1'b0) begin n_bad++; $display("FAIL credit_return%0d: got %b want 0", i, can_issue); end
        end
        valid = 1'b0;
        step;
        n_cmp++; if (can_issue !== 1'b0) begin n_bad++; $display("FAIL credit_full: got %b want 0", can_issue); end
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL credit_full_valid: got %b want 1", o_valid); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_q !== 10'(20 + i)) begin n_bad++; $display("FAIL credit_drain%0d: got %0d want %0d", i, o_q, 20 + i); end
            step;
            n_cmp++; if (can_issue !== 1'b1) begin n_bad++; $display("FAIL credit_reopen%0d: got %b want 1", i, can_issue); end
        end
        ready = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL credit_empty: got %b want 0", o_valid); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) begin
            drive(10 + i, 0, 1);
            step;
        end
        drive(14, 0, 1);
        step;
        valid = 1'b0;
        ready = 1'b1;
        step;
        ready = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_simul_pop: got %b want 0", ovf); end
        n_cmp++; if (o_q !== 10'd11) begin n_bad++; $display("FAIL ovf_simul_head: got %0d want 11", o_q); end
        drive(99, 0, 1);
        step;
        valid = 1'b0;
        step;
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
        n_cmp++; if (o_q !== 10'd11) begin n_bad++; $display("FAIL ovf_head_stable: got %0d want 11", o_q); end
        step;
        step;
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_q !== 10'(11 + i)) begin n_bad++; $display("FAIL ovf_drain%0d: got %0d want %0d", i, o_q, 11 + i); end
            step;
        end
        ready = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_dropped_entry: got valid %b want 0", o_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_reset_clear: got %b want 0", ovf); end
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_back_to_back;
        int pt[$];
        logic [9:0] pq[$], pr[$], pd[$], xq[$], xm[$];
        int issued = 0, got = 0, outstanding = 0;
        int n, d, m;
        for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
            n_cmp++; if (can_issue !== (outstanding < D)) begin n_bad++; $display("FAIL b2b_credit c%0d: got %b want %b (outstanding %0d)", cyc, can_issue, outstanding < D, outstanding); end
            issue = can_issue && issued < 20;
            if (issue) begin
                n = int'($urandom_range(1000)) - 500;
                d = int'($urandom_range(20, 1));
                pt.push_back(cyc + 3);
                pq.push_back(10'(n / d));
                pr.push_back(10'(n % d));
                pd.push_back(10'(d));
                m = ((n % d) + d) % d;
                xq.push_back(10'((n - m) / d));
                xm.push_back(10'(m));
                issued++;
                outstanding++;
            end
            valid = 1'b0;
            if (pt.size() > 0 && pt[0] == cyc) begin
                valid = 1'b1;
                q_in = pq.pop_front();
                r_in = pr.pop_front();
                d_in = pd.pop_front();
                void'(pt.pop_front());
            end
            ready = 1'($urandom_range(1));
            if (o_valid && ready) begin
                n_cmp++; if ({o_q, o_m} !== {xq[0], xm[0]}) begin n_bad++; $display("FAIL b2b_result%0d: got q=%0d m=%0d want q=%0d m=%0d", got, $signed(o_q), o_m, $signed(xq[0]), xm[0]); end
                void'(xq.pop_front());
                void'(xm.pop_front());
                got++;
                outstanding--;
            end
            step;
        end
        issue = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        n_cmp++; if (got !== 20) begin n_bad++; $display("FAIL b2b_count: got %0d want 20", got); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_no_drop: got overflow %b want 0", ovf); end
    endtask

    task automatic test_reset_midop;
        for (int i = 0; i < 3; i++) begin
            drive(40 + i, 0, 1);
            step;
        end
        valid = 1'b0;
        issue = 1'b1;
        step;
        step;
        issue = 1'b0;
        n_cmp++; if (can_issue !== 1'b0) begin n_bad++; $display("FAIL midop_loaded: got %b want 0", can_issue); end
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL midop_buffered: got %b want 1", o_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midop_valid: got %b want 0", o_valid); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL midop_overflow: got %b want 0", ovf); end
        n_cmp++; if (can_issue !== 1'b1) begin n_bad++; $display("FAIL midop_can_issue: got %b want 1", can_issue); end
        #2 rst_n = 1'b1;
        step;
        drive(-3, -1, 2);
        step;
        valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midop_lat_early: got %b want 0", o_valid); end
        step;
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL midop_lat: got %b want 1", o_valid); end
        n_cmp++; if ({o_q, o_m} !== {10'h3FC, 10'd1}) begin n_bad++; $display("FAIL midop_result: got q=%0d m=%0d want q=-4 m=1", $signed(o_q), o_m); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_floor;
        test_credit;
        test_overflow;
        test_back_to_back;
        test_reset_midop;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
